operand_fetch: RTL and testbench

Operand-read front end for the register file. It accepts register-read requests from decode, drives the register file's synchronous read ports, and absorbs their one-cycle read latency. It forwards same-cycle and later writeback data so that returned operands are never stale. Operands are held in a small snooping buffer and handed to execute over a valid/ready handshake without loss under backpressure.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/operand_fifo.sv | 71 +++++++
 rtl/operand_fetch.sv | 112 +++++++++++
 tb/tb_operand_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file front-end types and constants.
// No logic; used by operand_fetch and operand_fifo.
// Holds the operand FIFO entry layout and the writeback-match helper.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int TAG_WIDTH      = 32;
  localparam int FIFO_DEPTH     = 3;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [XLEN-1:0]           rs1_data;
    logic [XLEN-1:0]           rs2_data;
    logic [TAG_WIDTH-1:0]      tag;
  } operand_entry_t;

  // A writeback forwards to a source operand when it targets that register.
  // x0 is hard-wired, so it never matches.
  function automatic logic fwd_hit(input logic                      we,
                                   input logic [REG_ADDR_WIDTH-1:0] waddr,
                                   input logic [REG_ADDR_WIDTH-1:0] rs);
    return we && (waddr != '0) && (waddr == rs);
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// 3-entry in-order operand FIFO whose stored operands are snooped by writeback.
// Latency: a pushed entry is visible at the head the following cycle.
// Backpressure: no internal stall; the producer must not push when full.
module operand_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  riscv_pkg::operand_entry_t i_push_entry,
  input  logic        i_pop,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_waddr,
  input  logic [31:0] i_wb_wdata,
  output logic [1:0]  o_count,
  output logic [31:0] o_head_rs1_data,
  output logic [31:0] o_head_rs2_data,
  output logic [31:0] o_head_tag
);
  import riscv_pkg::*;

  operand_entry_t r_mem [FIFO_DEPTH];
  logic [1:0]     r_rd_ptr;
  logic [1:0]     r_wr_ptr;
  logic [1:0]     r_count;
  logic           w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop = i_pop && (r_count != 2'd0);

  // Storage, pointers and occupancy; every entry snoops writeback, a push overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (fwd_hit(i_wb_we, i_wb_waddr, r_mem[i].rs1)) r_mem[i].rs1_data <= i_wb_wdata;
        if (fwd_hit(i_wb_we, i_wb_waddr, r_mem[i].rs2)) r_mem[i].rs2_data <= i_wb_wdata;
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation; reads as zero when empty.
  always_comb begin
    o_head_rs1_data = '0;
    o_head_rs2_data = '0;
    o_head_tag      = '0;
    if (r_count != 2'd0) begin
      o_head_rs1_data = r_mem[r_rd_ptr].rs1_data;
      o_head_rs2_data = r_mem[r_rd_ptr].rs2_data;
      o_head_tag      = r_mem[r_rd_ptr].tag;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/operand_fetch.sv
// Register-read front end: issue -> S1 (RF read latency) -> snooping operand FIFO.
// Latency: accept at T, operands valid at T+2.
// Backpressure: req_ready from registered occupancy only; S1 never stalls.
module operand_fetch #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs2,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [XLEN-1:0]           wb_wdata,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [XLEN-1:0]           op_rs1_data,
  output logic [XLEN-1:0]           op_rs2_data,
  output logic [TAG_WIDTH-1:0]      op_tag
);
  import riscv_pkg::*;

  logic                      r_s1_valid;
  logic [REG_ADDR_WIDTH-1:0] r_s1_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_s1_rs2;
  logic [TAG_WIDTH-1:0]      r_s1_tag;
  logic                      r_s1_byp1;
  logic                      r_s1_byp2;
  logic [XLEN-1:0]           r_s1_bdat1;
  logic [XLEN-1:0]           r_s1_bdat2;

  logic                      w_accept;
  logic [2:0]                w_occupancy;
  logic [1:0]                w_count;
  operand_entry_t            w_s1_entry;

  // Reads are issued unconditionally; the RF has no side effects on read.
  assign rf_raddr1 = req_rs1;
  assign rf_raddr2 = req_rs2;

  // S1 plus FIFO can hold at most three in-flight requests.
  assign w_occupancy = {2'b00, r_s1_valid} + {1'b0, w_count};
  assign req_ready   = (w_occupancy < 3'd3);
  assign w_accept    = req_valid && req_ready;

  // S1 capture; a same-edge writeback is missed by the RF so it is latched here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_tag   <= '0;
      r_s1_byp1  <= 1'b0;
      r_s1_byp2  <= 1'b0;
      r_s1_bdat1 <= '0;
      r_s1_bdat2 <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_rs1   <= req_rs1;
        r_s1_rs2   <= req_rs2;
        r_s1_tag   <= req_tag;
        r_s1_byp1  <= fwd_hit(wb_we, wb_waddr, req_rs1);
        r_s1_byp2  <= fwd_hit(wb_we, wb_waddr, req_rs2);
        r_s1_bdat1 <= wb_wdata;
        r_s1_bdat2 <= wb_wdata;
      end
    end
  end

  // Operand selection in S1: live writeback beats latched bypass beats RF data.
  always_comb begin
    w_s1_entry      = '0;
    w_s1_entry.rs1  = r_s1_rs1;
    w_s1_entry.rs2  = r_s1_rs2;
    w_s1_entry.tag  = r_s1_tag;
    if (r_s1_rs1 == '0)                          w_s1_entry.rs1_data = '0;
    else if (fwd_hit(wb_we, wb_waddr, r_s1_rs1)) w_s1_entry.rs1_data = wb_wdata;
    else if (r_s1_byp1)                          w_s1_entry.rs1_data = r_s1_bdat1;
    else                                         w_s1_entry.rs1_data = rf_rdata1;
    if (r_s1_rs2 == '0)                          w_s1_entry.rs2_data = '0;
    else if (fwd_hit(wb_we, wb_waddr, r_s1_rs2)) w_s1_entry.rs2_data = wb_wdata;
    else if (r_s1_byp2)                          w_s1_entry.rs2_data = r_s1_bdat2;
    else                                         w_s1_entry.rs2_data = rf_rdata2;
  end

  operand_fifo u_fifo (
    .clk             (clk),
    .rst             (rst),
    .i_push          (r_s1_valid),
    .i_push_entry    (w_s1_entry),
    .i_pop           (op_valid && op_ready),
    .i_wb_we         (wb_we),
    .i_wb_waddr      (wb_waddr),
    .i_wb_wdata      (wb_wdata),
    .o_count         (w_count),
    .o_head_rs1_data (op_rs1_data),
    .o_head_rs2_data (op_rs2_data),
    .o_head_tag      (op_tag)
  );

  assign op_valid = (w_count != 2'd0);

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural synchronous-read RF.
// Expected results are queued at request time and popped on each consume.
// Covers latency, forwarding, x0, snoop, backpressure and reset flush.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_tag = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] op_rs1_data, op_rs2_data, op_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] tag;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] tag;
    logic        iss_we;  logic [4:0] iss_addr; logic [31:0] iss_data;
    logic        s1_we;   logic [4:0] s1_addr;  logic [31:0] s1_data;
    logic [31:0] exp1, exp2;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] rf [32];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_tag(op_tag)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read returns the pre-write value on a same-edge write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
      rf[0] <= '0;
      rf[5] <= 32'h0000_1234;
      rf[6] <= 32'h0000_ABCD;
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else begin
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
      if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] tag, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.tag = tag; e.d1 = d1; e.d2 = d2;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every consume must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", op_tag, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_tag", op_tag, e.tag);
        check("sb_rs1", op_rs1_data, e.d1);
        check("sb_rs2", op_rs2_data, e.d2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int waited;
    vecs[0] = '{5'd5, 5'd6, 32'h10, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         32'h0000_1234, 32'h0000_ABCD};
    vecs[1] = '{5'd5, 5'd7, 32'h11, 1'b1, 5'd5, 32'hDEADBEEF,  1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  32'h0000_0107};
    vecs[2] = '{5'd5, 5'd0, 32'h12, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0};
    vecs[3] = '{5'd0, 5'd6, 32'h13, 1'b1, 5'd0, 32'hFFFFFFFF,  1'b0, 5'd0, 32'h0,         32'h0,         32'h0000_ABCD};
    vecs[4] = '{5'd8, 5'd8, 32'h14, 1'b0, 5'd0, 32'h0,         1'b1, 5'd8, 32'h88,        32'h88,        32'h88};
    vecs[5] = '{5'd9, 5'd5, 32'h15, 1'b1, 5'd9, 32'h99,        1'b0, 5'd0, 32'h0,         32'h99,        32'hCAFEF00D};
    vecs[6] = '{5'd6, 5'd6, 32'h16, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'h7777,      32'h0000_ABCD, 32'h0000_ABCD};

    // Reset state.
    req_rs1 = 5'd3;
    #1;
    check("rst_op_valid", {31'b0, op_valid}, 32'h0);
    check("rst_op_tag", op_tag, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_raddr1", {27'b0, rf_raddr1}, 32'h3);
    step();
    step();
    rst = 1'b0;

    // Table-driven single requests with issue-cycle and S1-cycle writebacks.
    for (int i = 0; i < 7; i++) begin
      check("vec_req_ready", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_rs1 = vecs[i].rs1; req_rs2 = vecs[i].rs2; req_tag = vecs[i].tag;
      wb_we = vecs[i].iss_we; wb_waddr = vecs[i].iss_addr; wb_wdata = vecs[i].iss_data;
      push_exp(vecs[i].tag, vecs[i].exp1, vecs[i].exp2);
      step();
      req_valid = 1'b0;
      wb_we = vecs[i].s1_we; wb_waddr = vecs[i].s1_addr; wb_wdata = vecs[i].s1_data;
      @(negedge clk);
      check("vec_not_early", {31'b0, op_valid}, 32'h0);
      step();
      wb_we = 1'b0;
      @(negedge clk);
      check("vec_valid_t2", {31'b0, op_valid}, 32'h1);
      step();
    end

    // Held-entry snoop: three entries parked, then x6 rewritten.
    op_ready = 1'b0;
    req_valid = 1'b1;
    req_rs1 = 5'd1; req_rs2 = 5'd6; req_tag = 32'h20; push_exp(32'h20, 32'h101, 32'h55); step();
    req_rs1 = 5'd6; req_rs2 = 5'd6; req_tag = 32'h21; push_exp(32'h21, 32'h55, 32'h55);  step();
    req_rs1 = 5'd2; req_rs2 = 5'd3; req_tag = 32'h22; push_exp(32'h22, 32'h102, 32'h103); step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    check("snoop_full_ready", {31'b0, req_ready}, 32'h0);
    check("snoop_head_tag", op_tag, 32'h20);
    check("snoop_head_old", op_rs2_data, 32'h0000_ABCD);
    step();
    wb_we = 1'b1; wb_waddr = 5'd6; wb_wdata = 32'h55;
    step();
    wb_we = 1'b0;
    @(negedge clk);
    check("snoop_head_new", op_rs2_data, 32'h55);
    check("snoop_head_rs1", op_rs1_data, 32'h101);
    step();
    op_ready = 1'b1;
    step();
    @(negedge clk);
    check("snoop_ready_back", {31'b0, req_ready}, 32'h1);
    step(); step(); step();

    // Backpressure: request held for five cycles against a stalled consumer.
    op_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_tag = 32'h30 + acc;
      req_rs1 = 5'(10 + acc);
      req_rs2 = 5'(11 + acc);
      @(negedge clk);
      if (req_ready) begin
        push_exp(32'h30 + acc, 32'h100 + 10 + acc, 32'h100 + 11 + acc);
        acc++;
      end
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, 32'd3);
    @(negedge clk);
    check("bp_ready_low", {31'b0, req_ready}, 32'h0);
    step();
    op_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_b2b_valid", {31'b0, op_valid}, 32'h1);
      if (c == 1) check("bp_ready_reassert", {31'b0, req_ready}, 32'h1);
      step();
    end

    // Drain whatever is outstanding, bounded.
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    // Reset mid-operation with two entries queued.
    op_ready = 1'b0;
    req_valid = 1'b1;
    req_rs1 = 5'd1; req_rs2 = 5'd2; req_tag = 32'h40; step();
    req_tag = 32'h41; step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    check("pre_rst_valid", {31'b0, op_valid}, 32'h1);
    step();
    req_rs1 = 5'd17;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, op_valid}, 32'h0);
    check("mid_rst_rs1", op_rs1_data, 32'h0);
    check("mid_rst_tag", op_tag, 32'h0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    check("mid_rst_raddr", {27'b0, rf_raddr1}, 32'd17);
    step();
    rst = 1'b0;
    op_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_valid", {31'b0, op_valid}, 32'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
